// File: rtl/connect_four_pkg.sv
// Shared player codes, GRB colour helpers and LED driver FSM encoding.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package connect_four_pkg;

   // Board cell / player codes; 2'b11 is unused and renders dark
   localparam logic [1:0] EMPTY   = 2'b00;
   localparam logic [1:0] PLAYER1 = 2'b01;
   localparam logic [1:0] PLAYER2 = 2'b10;

   // LED driver FSM states
   localparam logic [1:0] GAP   = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] SEND  = 2'd2;

   // One WS2812 pixel, green first on the wire
   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } grb_t;

   localparam grb_t GRB_OFF = '0;

   function automatic grb_t grb_red(input logic [7:0] bright);
      grb_red = {8'h00, bright, 8'h00};
   endfunction

   function automatic grb_t grb_yellow(input logic [7:0] bright);
      grb_yellow = {bright, bright, 8'h00};
   endfunction

   function automatic grb_t grb_white(input logic [7:0] bright);
      grb_white = {bright, bright, bright};
   endfunction

   // Colour shown for a player code; anything but P1/P2 is dark
   function automatic grb_t player_colour(input logic [1:0] code, input logic [7:0] bright);
      case (code)
         PLAYER1: player_colour = grb_red(bright);
         PLAYER2: player_colour = grb_yellow(bright);
         default: player_colour = GRB_OFF;
      endcase
   endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Serialises one 24-bit GRB word MSB first as WS2812 high/low bit cells.
// Latency: dout goes high on the load edge; done is high in the last clock of bit 0.
// Backpressure: none; load is only issued while idle, a load mid-word restarts it.
module ws2812_bit_tx #(
   parameter int T0H  = 20,
   parameter int T1H  = 40,
   parameter int TBIT = 63
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [23:0] word,
   output logic        dout,
   output logic        done
);

   localparam int CW = $clog2(TBIT + 1);
   localparam logic [CW-1:0] LAST = CW'(TBIT - 1);
   localparam logic [CW-1:0] H0   = CW'(T0H);
   localparam logic [CW-1:0] H1   = CW'(T1H);

   logic [23:0]   shreg;
   logic [4:0]    bit_cnt;
   logic [CW-1:0] cyc;
   logic [CW-1:0] cyc_nxt;
   logic [CW-1:0] high_len;
   logic          busy;

   assign cyc_nxt  = cyc + CW'(1);
   assign high_len = shreg[23] ? H1 : H0;
   // Parent uses this to move on exactly as the last low phase ends
   assign done     = busy && (cyc == LAST) && (bit_cnt == 5'd0);

   // Bit-cell sequencer: high while inside the bit's high time, low for the rest of TBIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         cyc     <= '0;
         busy    <= 1'b0;
         dout    <= 1'b0;
      end else if (load) begin
         shreg   <= word;
         bit_cnt <= 5'd23;
         cyc     <= '0;
         busy    <= 1'b1;
         dout    <= 1'b1;
      end else if (busy) begin
         if (cyc == LAST) begin
            cyc <= '0;
            if (bit_cnt == 5'd0) begin
               busy <= 1'b0;
               dout <= 1'b0;
            end else begin
               shreg   <= {shreg[22:0], 1'b0};
               bit_cnt <= bit_cnt - 5'd1;
               dout    <= 1'b1;
            end
         end else begin
            cyc  <= cyc_nxt;
            dout <= (cyc_nxt < high_len);
         end
      end
   end

endmodule

// File: rtl/board_led_driver.sv
// Scans the 8x8 board plus an 8-pixel cursor strip and streams it as WS2812 GRB data.
// Latency: first bit TRESET+FETCH_WAIT+1 clocks after reset; each pixel costs FETCH_WAIT+1+24*TBIT.
// Backpressure: none; free-running, enable is only sampled at the end of the inter-frame gap.
module board_led_driver
   import connect_four_pkg::*;
#(
   parameter int          T0H        = 20,
   parameter int          T1H        = 40,
   parameter int          TBIT       = 63,
   parameter int          TRESET     = 4000,
   parameter int          FETCH_WAIT = 2,
   parameter logic [7:0]  BRIGHT     = 8'h20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] cell_data,
   input  logic       cell_winning,
   input  logic [2:0] cursor_col,
   input  logic [1:0] cursor_player,
   output logic [2:0] row_read,
   output logic [2:0] col_read,
   output logic       led_dout,
   output logic       frame_done
);

   localparam int CMAX = (TRESET > TBIT) ? TRESET : TBIT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(TRESET - 1);
   localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_WAIT);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [6:0]    pix;
   logic [6:0]    pix_next;
   grb_t          colour;
   logic          load;
   logic          tx_done;

   assign pix_next = pix + 7'd1;
   // Colour is captured by the serialiser on the same edge that ends FETCH
   assign load     = (state == FETCH) && (cnt == FETCH_LAST);

   // Map the addressed cell (or cursor slot) to its pixel colour
   always_comb begin
      colour = GRB_OFF;
      if (!pix[6]) begin
         if (cell_winning && (cell_data != EMPTY))
            colour = grb_white(BRIGHT);
         else
            colour = player_colour(cell_data, BRIGHT);
      end else if (col_read == cursor_col) begin
         colour = player_colour(cursor_player, BRIGHT);
      end
   end

   // Frame sequencer: reset gap, per-pixel address/fetch, then hand off to the serialiser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= GAP;
         cnt        <= '0;
         pix        <= '0;
         row_read   <= '0;
         col_read   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            GAP: begin
               if (cnt == GAP_LAST) begin
                  // Hold at terminal count while disabled so restart is immediate
                  if (enable) begin
                     state    <= FETCH;
                     cnt      <= '0;
                     pix      <= '0;
                     row_read <= '0;
                     col_read <= '0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FETCH: begin
               if (cnt == FETCH_LAST) begin
                  state <= SEND;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            SEND: begin
               if (tx_done) begin
                  if (pix == 7'd71) begin
                     state      <= GAP;
                     frame_done <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     pix      <= pix_next;
                     // Cursor strip reads row 0, column = pixel - 64
                     row_read <= pix_next[6] ? 3'd0 : pix_next[5:3];
                     col_read <= pix_next[2:0];
                  end
               end
            end
            default: begin
               state <= GAP;
               cnt   <= '0;
            end
         endcase
      end
   end

   ws2812_bit_tx #(
      .T0H  (T0H),
      .T1H  (T1H),
      .TBIT (TBIT)
   ) u_bit_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .word  (colour),
      .dout  (led_dout),
      .done  (tx_done)
   );

endmodule

// File: tb/tb_board_led_driver.sv
// Self-checking bench for board_led_driver: decodes the WS2812 line and compares frames
// against a board/cursor reference model, plus gap, restart and async-reset timing.
// Uses shortened bit/gap timings so several full frames fit in a short run.
module tb_board_led_driver;

   localparam int T0H    = 1;
   localparam int T1H    = 2;
   localparam int TBIT   = 4;
   localparam int TRESET = 40;
   localparam int FW     = 2;
   localparam logic [7:0] BR = 8'h20;
   localparam int FRAME  = TRESET + 72 * (FW + 1) + 72 * 24 * TBIT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] cell_data;
   logic       cell_winning;
   logic [2:0] cursor_col = 3'd0;
   logic [1:0] cursor_player = 2'd0;
   logic [2:0] row_read;
   logic [2:0] col_read;
   logic       led_dout;
   logic       frame_done;

   logic [1:0] board [8][8];
   logic       win   [8][8];

   assign cell_data    = board[row_read][col_read];
   assign cell_winning = win[row_read][col_read];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   board_led_driver #(
      .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET),
      .FETCH_WAIT(FW), .BRIGHT(BR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .cell_data(cell_data), .cell_winning(cell_winning),
      .cursor_col(cursor_col), .cursor_player(cursor_player),
      .row_read(row_read), .col_read(col_read),
      .led_dout(led_dout), .frame_done(frame_done)
   );

   // ---------------- line decoder ----------------
   logic [23:0] pix_q[$];
   int          bad_pulse = 0;
   int          rise_count = 0;
   int          first_rise = 0;
   bit          rise_armed = 0;
   int          done_hi = 0;
   int          done_cyc = 0;
   logic        prev = 1'b0;
   int          hi_len = 0;
   int          bitn = 0;
   logic [23:0] word = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev = 1'b0; hi_len = 0; bitn = 0; word = '0;
      end else begin
         if (led_dout) begin
            if (!prev) begin
               hi_len = 0;
               rise_count++;
               if (rise_armed) begin first_rise = cyc; rise_armed = 0; end
            end
            hi_len++;
         end else if (prev) begin
            if (hi_len == T1H)      word = {word[22:0], 1'b1};
            else if (hi_len == T0H) word = {word[22:0], 1'b0};
            else begin bad_pulse++; word = {word[22:0], 1'b0}; end
            bitn++;
            if (bitn == 24) begin pix_q.push_back(word); bitn = 0; end
         end
         prev = led_dout;
         if (frame_done) begin done_hi++; done_cyc = cyc; end
      end
   end

   // ---------------- checking helpers ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   function automatic logic [23:0] colour_of(input int code);
      if (code == 1) return {8'h00, BR, 8'h00};
      if (code == 2) return {BR, BR, 8'h00};
      return 24'h0;
   endfunction

   // Reference: what pixel p should show given the current board and cursor
   function automatic logic [23:0] exp_pix(input int p);
      int r, c;
      if (p < 64) begin
         r = p / 8;
         c = p % 8;
         if (win[r][c] && board[r][c] != 2'b00) return {BR, BR, BR};
         return colour_of(int'(board[r][c]));
      end
      if (p - 64 == int'(cursor_col)) return colour_of(int'(cursor_player));
      return 24'h0;
   endfunction

   function automatic logic [23:0] got(input int p);
      if (p < pix_q.size()) return pix_q[p];
      return 24'hxxxxxx;
   endfunction

   task automatic clear_mon();
      pix_q.delete();
      bad_pulse = 0;
   endtask

   task automatic rand_board();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            board[r][c] = 2'($urandom_range(0, 3));
            win[r][c]   = ($urandom_range(0, 3) == 0);
         end
      cursor_col    = 3'($urandom_range(0, 7));
      cursor_player = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(input string tag);
      int base;
      base = done_hi;
      for (int i = 0; i < 3 * FRAME && done_hi == base; i++) step(1);
      check({tag, "_done_seen"}, 32'(done_hi != base), 1);
   endtask

   task automatic check_frame(input string tag, input int base_done);
      step(2);
      check({tag, "_done_pulses"}, done_hi - base_done, 1);
      check({tag, "_pixel_count"}, pix_q.size(), 72);
      check({tag, "_bad_pulses"}, bad_pulse, 0);
      for (int p = 0; p < 72; p++)
         check($sformatf("%s_px%0d", tag, p), got(p), exp_pix(p));
   endtask

   // ---------------- directed sequence ----------------
   int rel, base, d0, rc, dh, e;

   initial begin
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin board[r][c] = 2'b00; win[r][c] = 1'b0; end
      enable = 1'b1;
      step(3);
      check("rst_led", led_dout, 0);
      check("rst_row", row_read, 0);
      check("rst_col", col_read, 0);
      check("rst_done", frame_done, 0);

      // Frame 0: empty board straight out of reset
      clear_mon();
      rise_armed = 1;
      base = done_hi;
      rst_n = 1'b1;
      rel = cyc;
      wait_done("f0");
      check("f0_first_bit", first_rise - rel, TRESET + FW + 1);
      check("f0_length", done_cyc - rel, FRAME);
      check_frame("f0", base);

      // Frame 1: directed cells and cursor
      board[0][0] = 2'b01;
      board[7][7] = 2'b10;
      board[3][4] = 2'b01; win[3][4] = 1'b1;
      win[5][5]   = 1'b1;
      cursor_col = 3'd5; cursor_player = 2'b10;
      clear_mon();
      d0 = done_cyc;
      rise_armed = 1;
      base = done_hi;
      wait_done("f1");
      check("f1_gap", first_rise - d0, TRESET + FW + 1);
      check_frame("f1", base);
      check("f1_p1_cell00", got(0), 24'h002000);
      check("f1_p2_cell77", got(63), 24'h202000);
      check("f1_win_cell34", got(28), 24'h202020);
      check("f1_win_empty55", got(45), 24'h000000);
      check("f1_cursor69", got(69), 24'h202000);
      check("f1_cursor64", got(64), 24'h000000);
      check("f1_cursor68", got(68), 24'h000000);
      check("f1_cursor70", got(70), 24'h000000);
      check("f1_cursor71", got(71), 24'h000000);

      // Frame 2: random board
      rand_board();
      clear_mon();
      base = done_hi;
      wait_done("f2");
      check_frame("f2", base);

      // Frame 3: enable dropped mid-frame, frame still completes
      rand_board();
      clear_mon();
      base = done_hi;
      for (int i = 0; i < 2 * FRAME && pix_q.size() < 30; i++) step(1);
      check("f3_reached_px30", 32'(pix_q.size() >= 30), 1);
      enable = 1'b0;
      wait_done("f3");
      check_frame("f3", base);
      rc = rise_count;
      dh = done_hi;
      step(3 * TRESET);
      check("idle_rises", rise_count - rc, 0);
      check("idle_done", done_hi - dh, 0);
      check("idle_led", led_dout, 0);

      // Frame 4: re-enable starts a frame after the held gap
      rand_board();
      clear_mon();
      base = done_hi;
      rise_armed = 1;
      enable = 1'b1;
      e = cyc;
      wait_done("f4");
      check("f4_restart", first_rise - e, FW + 2);
      check_frame("f4", base);

      // Async reset while the line is high
      rand_board();
      clear_mon();
      for (int i = 0; i < 2 * FRAME && pix_q.size() < 5; i++) step(1);
      for (int i = 0; i < 50 && !led_dout; i++) step(1);
      check("rst_mid_pre_high", led_dout, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_led", led_dout, 0);
      check("rst_mid_done", frame_done, 0);
      step(3);
      check("rst_mid_row", row_read, 0);
      check("rst_mid_col", col_read, 0);
      clear_mon();
      rise_armed = 1;
      base = done_hi;
      rst_n = 1'b1;
      rel = cyc;
      wait_done("f5");
      check("f5_first_bit", first_rise - rel, TRESET + FW + 1);
      check("f5_length", done_cyc - rel, FRAME);
      check_frame("f5", base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
